pc_fetch_unit: RTL and testbench

- Parametrised next-generation program counter for the pipelined MIPS core; sits at the head of the F stage and drives the instruction-memory address.
- Adds the following on top of the basic single-cycle PC:
  - stall hold;
  - a pending-redirect latch, so redirects arriving during a stall are not lost;
  - exception entry and ERET return;
  - configurable width and reset vector.
- Branch/jump redirects come from the D stage. Exception and ERET controls come from the CP0/M stage.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/pc_fetch_unit_if.sv | 53 +++++
 rtl/npc_calc.sv | 50 +++++
 rtl/pc_fetch_unit.sv | 117 +++++++++++
 tb/tb_pc_fetch_unit.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: next-pc select codes,
// default vectors and the fetch-unit state type.
package mips_pkg;

  localparam logic [2:0] NPC_SEQ = 3'b000;
  localparam logic [2:0] NPC_BR  = 3'b001;
  localparam logic [2:0] NPC_J   = 3'b010;
  localparam logic [2:0] NPC_JR  = 3'b011;

  localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY_DEF  = 32'h0000_4180;
  localparam logic [31:0] IM_LO_DEF      = 32'h0000_3000;
  localparam logic [31:0] IM_HI_DEF      = 32'h0000_6FFC;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } pc_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control/redirect bundle between D/M stages and the fetch PC.
// master = pipeline control side, slave = pc_fetch_unit.
interface pc_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              stall;
  logic [2:0]        npc_sel;
  logic [ADDR_W-1:0] br_base;
  logic [15:0]       br_imm;
  logic [25:0]       j_idx;
  logic [ADDR_W-1:0] rs_val;
  logic              exc_req;
  logic              eret;
  logic [ADDR_W-1:0] epc;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus8;
  logic              pend_valid;
  logic              adel;

  modport master (
    output stall,
    output npc_sel,
    output br_base,
    output br_imm,
    output j_idx,
    output rs_val,
    output exc_req,
    output eret,
    output epc,
    input  pc,
    input  pc_plus8,
    input  pend_valid,
    input  adel
  );

  modport slave (
    input  stall,
    input  npc_sel,
    input  br_base,
    input  br_imm,
    input  j_idx,
    input  rs_val,
    input  exc_req,
    input  eret,
    input  epc,
    output pc,
    output pc_plus8,
    output pend_valid,
    output adel
  );

endinterface

// File: rtl/npc_calc.sv
// Combinational redirect target for branch / j / jr.
// redir flags a recognised redirect code; others act as sequential.
module npc_calc
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [2:0]        npc_sel,
  input  logic [ADDR_W-1:0] br_base,
  input  logic [15:0]       br_imm,
  input  logic [25:0]       j_idx,
  input  logic [ADDR_W-1:0] rs_val,
  output logic [ADDR_W-1:0] tgt,
  output logic              redir
);

  logic [ADDR_W-1:0] base4;
  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] tgt_br;
  logic [ADDR_W-1:0] tgt_j;
  logic              is_br;
  logic              is_j;
  logic              is_jr;

  assign base4  = br_base + ADDR_W'(4);
  assign off    = {{(ADDR_W-18){br_imm[15]}}, br_imm, 2'b00};
  assign tgt_br = base4 + off;

  // upper region bits come from the delay-slot pc
  always_comb begin
    tgt_j        = base4;
    tgt_j[27:0]  = {j_idx, 2'b00};
  end

  assign is_br = (npc_sel == NPC_BR);
  assign is_j  = (npc_sel == NPC_J);
  assign is_jr = (npc_sel == NPC_JR);
  assign redir = is_br | is_j | is_jr;

  always_comb begin
    tgt = base4;
    unique case (1'b1)
      is_br:   tgt = tgt_br;
      is_j:    tgt = tgt_j;
      is_jr:   tgt = rs_val;
      default: tgt = base4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC with stall hold, pending-redirect latch and exceptions.
// Define PC_ALIGN_CHECK_EN to build the registered adel fetch check.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_ADDR_DEF),
  parameter logic [ADDR_W-1:0] EXC_ENTRY  = ADDR_W'(EXC_ENTRY_DEF)
`ifdef PC_ALIGN_CHECK_EN
  ,
  parameter logic [ADDR_W-1:0] IM_LO      = ADDR_W'(IM_LO_DEF),
  parameter logic [ADDR_W-1:0] IM_HI      = ADDR_W'(IM_HI_DEF)
`endif
) (
  input  logic           clk,
  input  logic           reset,
  pc_fetch_unit_if.slave bus
);

  pc_state_t         state_q;
  pc_state_t         state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pend_q;
  logic [ADDR_W-1:0] pend_d;
  logic [ADDR_W-1:0] tgt;
  logic              redir;
  logic              flush;

  npc_calc #(
    .ADDR_W (ADDR_W)
  ) u_npc_calc (
    .npc_sel (bus.npc_sel),
    .br_base (bus.br_base),
    .br_imm  (bus.br_imm),
    .j_idx   (bus.j_idx),
    .rs_val  (bus.rs_val),
    .tgt     (tgt),
    .redir   (redir)
  );

  assign flush = bus.exc_req | bus.eret;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_ADDR;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = RUN;
    end else if (bus.stall) begin
      if (state_q == RUN && redir)
        state_d = HOLD;
    end else begin
      state_d = RUN;
    end
  end

  // exc_req outranks eret; both outrank stall
  always_comb begin
    pc_d   = pc_q + ADDR_W'(4);
    pend_d = pend_q;
    if (bus.exc_req) begin
      pc_d   = EXC_ENTRY;
      pend_d = '0;
    end else if (bus.eret) begin
      pc_d   = bus.epc;
      pend_d = '0;
    end else if (bus.stall) begin
      pc_d = pc_q;
      if (state_q == RUN && redir)
        pend_d = tgt;
    end else if (state_q == HOLD) begin
      pc_d   = pend_q;
      pend_d = '0;
    end else if (redir) begin
      pc_d = tgt;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus8   = pc_q + ADDR_W'(8);
  assign bus.pend_valid = (state_q == HOLD);

`ifdef PC_ALIGN_CHECK_EN
  logic adel_q;
  logic adel_d;

  // pc still loads the faulting value so BadVAddr can be recorded
  always_comb begin
    adel_d = (pc_d[1:0] != 2'b00)
           | (pc_d < IM_LO)
           | (pc_d > IM_HI);
  end

  always_ff @(posedge clk) begin
    if (reset)
      adel_q <= 1'b0;
    else
      adel_q <= adel_d;
  end

  assign bus.adel = adel_q;
`else
  assign bus.adel = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed plan + random traffic
// against a queue-based next-pc model.
module tb_pc_fetch_unit;
  import mips_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic        pv;
    logic        adel;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pc_fetch_unit_if #(.ADDR_W(32)) bus ();

  pc_fetch_unit #(.ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];

  function automatic logic [31:0] tgt_of(
    input logic [2:0]  sel,
    input logic [31:0] base,
    input logic [15:0] imm,
    input logic [25:0] jidx,
    input logic [31:0] rs
  );
    logic [31:0] simm;
    simm = 32'(signed'(imm));
    case (sel)
      3'd1:    return base + 32'd4 + simm * 32'd4;
      3'd2:    return ((base + 32'd4) & 32'hF000_0000) | ({6'd0, jidx} << 2);
      3'd3:    return rs;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic bad_addr(input logic [31:0] a);
`ifdef PC_ALIGN_CHECK_EN
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
`else
    return 1'b0 & a[0];
`endif
  endfunction

  task automatic step(
    input logic        rst,
    input logic        st,
    input logic [2:0]  sel,
    input logic [31:0] base,
    input logic [15:0] imm,
    input logic [25:0] jidx,
    input logic [31:0] rs,
    input logic        ex,
    input logic        er,
    input logic [31:0] ep,
    input string       tag
  );
    exp_t e;
    logic is_r;
    @(negedge clk);
    reset       = rst;
    bus.stall   = st;
    bus.npc_sel = sel;
    bus.br_base = base;
    bus.br_imm  = imm;
    bus.j_idx   = jidx;
    bus.rs_val  = rs;
    bus.exc_req = ex;
    bus.eret    = er;
    bus.epc     = ep;
    is_r = (sel >= 3'd1 && sel <= 3'd3);
    if (rst) begin
      m_pc = 32'h3000;
      m_pend.delete();
    end else if (ex) begin
      m_pc = 32'h4180;
      m_pend.delete();
    end else if (er) begin
      m_pc = ep;
      m_pend.delete();
    end else if (st) begin
      if (is_r && m_pend.size() == 0)
        m_pend.push_back(tgt_of(sel, base, imm, jidx, rs));
    end else if (m_pend.size() != 0) begin
      m_pc = m_pend.pop_front();
    end else if (is_r) begin
      m_pc = tgt_of(sel, base, imm, jidx, rs);
    end else begin
      m_pc = m_pc + 32'd4;
    end
    e.pc   = m_pc;
    e.pv   = (m_pend.size() != 0);
    e.adel = rst ? 1'b0 : bad_addr(m_pc);
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic seq(input string tag);
    step(0, 0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h0, tag);
  endtask

  task automatic lit(input string tag, input logic [31:0] exp_pc, input logic exp_pv);
    @(posedge clk);
    #2;
    checks++;
    if (bus.pc !== exp_pc || bus.pend_valid !== exp_pv) begin
      errors++;
      $display("FAIL %s: got pc=%h pv=%b, want pc=%h pv=%b",
               tag, bus.pc, bus.pend_valid, exp_pc, exp_pv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.pc !== e.pc || bus.pc_plus8 !== e.pc + 32'd8 ||
            bus.pend_valid !== e.pv || bus.adel !== e.adel) begin
          errors++;
          $display("FAIL sb_%s: got pc=%h p8=%h pv=%b adel=%b, want pc=%h p8=%h pv=%b adel=%b",
                   e.tag, bus.pc, bus.pc_plus8, bus.pend_valid, bus.adel,
                   e.pc, e.pc + 32'd8, e.pv, e.adel);
        end
      end
    end
  end

  initial begin : stim
    logic [2:0]  sel;
    logic [31:0] base;
    logic [31:0] rs;
    int          wait_cyc;
    reset = 1'b1;
    bus.stall = 0; bus.npc_sel = 0; bus.br_base = 0; bus.br_imm = 0;
    bus.j_idx = 0; bus.rs_val = 0; bus.exc_req = 0; bus.eret = 0; bus.epc = 0;

    step(1, 0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h0, "reset");
    lit("reset_pc", 32'h3000, 1'b0);
    seq("seq1"); lit("seq1_pc", 32'h3004, 1'b0);
    seq("seq2"); lit("seq2_pc", 32'h3008, 1'b0);
    seq("seq3"); lit("seq3_pc", 32'h300C, 1'b0);

    step(0, 0, 3'd1, 32'h3008, 16'hFFFE, 26'h0, 32'h0, 0, 0, 32'h0, "br_neg");
    lit("br_neg_pc", 32'h3004, 1'b0);
    step(0, 0, 3'd1, 32'h3008, 16'h0003, 26'h0, 32'h0, 0, 0, 32'h0, "br_pos");
    lit("br_pos_pc", 32'h3018, 1'b0);

    step(0, 1, 3'd2, 32'h3010, 16'h0, 26'h0000C40, 32'h0, 0, 0, 32'h0, "st_j");
    lit("st_j_pc", 32'h3018, 1'b1);
    step(0, 1, 3'd3, 32'h3010, 16'h0, 26'h0, 32'h5000, 0, 0, 32'h0, "st_jr");
    step(0, 1, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h0, "st_seq");
    lit("st_hold_pc", 32'h3018, 1'b1);
    step(0, 0, 3'd3, 32'h0, 16'h0, 26'h0, 32'h6000, 0, 0, 32'h0, "release");
    lit("release_pc", 32'h3100, 1'b0);

    step(0, 1, 3'd2, 32'h3010, 16'h0, 26'h0000C40, 32'h0, 0, 0, 32'h0, "st_j2");
    step(0, 1, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 1, 0, 32'h0, "exc");
    lit("exc_pc", 32'h4180, 1'b0);
    step(0, 0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 0, 1, 32'h3010, "eret");
    lit("eret_pc", 32'h3010, 1'b0);
    step(0, 0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 1, 1, 32'h3010, "exc_eret");
    lit("exc_eret_pc", 32'h4180, 1'b0);
    step(0, 1, 3'd3, 32'h0, 16'h0, 26'h0, 32'h5000, 0, 0, 32'h0, "st_jr2");
    step(1, 1, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 0, 0, 32'h0, "rst_hold");
    lit("rst_hold_pc", 32'h3000, 1'b0);

    step(0, 0, 3'd3, 32'h0, 16'h0, 26'h0, 32'h3002, 0, 0, 32'h0, "jr_mis");
    step(0, 0, 3'd3, 32'h0, 16'h0, 26'h0, 32'h7000, 0, 0, 32'h0, "jr_hi");
    step(0, 0, 3'd3, 32'h0, 16'h0, 26'h0, 32'h6FF8, 0, 0, 32'h0, "jr_ok");
    seq("seq_top");
    seq("seq_over");
    step(0, 0, 3'd3, 32'h0, 16'h0, 26'h0, 32'h2FFC, 0, 0, 32'h0, "jr_lo");
    step(0, 0, 3'd3, 32'h0, 16'h0, 26'h0, 32'h3000, 0, 0, 32'h0, "jr_lo_ok");

    for (int i = 0; i < 3000; i++) begin
      sel  = 3'($urandom_range(0, 7));
      base = 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
      if ($urandom_range(0, 15) == 0)
        base = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      rs = 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
      if ($urandom_range(0, 3) == 0)
        rs = $urandom();
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 9) < 3,
           sel, base, 16'($urandom()), 26'($urandom()), rs,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 19) == 0,
           32'h3000 + ($urandom_range(0, 32'hFFF) << 2),
           "rnd");
    end

    wait_cyc = 0;
    while (sb.size() != 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
